sd_lade_sequenzer: RTL
======================

# sd_lade_sequenzer

Block-transfer sequencer directly upstream of the SD card word reader. On a single start pulse it fetches a run of consecutive 32-bit words from the SD card, one word request at a time, and writes each word into system RAM through a simple write handshake. Used at boot and for asset loading to copy program/data images from the card into memory without CPU involvement.

## Interface
Parameters:
- TIMEOUT, 24'd1048575: max cycles from an SdLesen pulse to the rising edge of SdFertig before the transfer aborts.

Ports:
- Clock  in  1  system clock; all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle pulse; starts a transfer, accepted only while Aktiv=0
- QuellAdresse  in  32  first SD word address (32-bit word units)
- ZielAdresse  in  32  first RAM word address
- Anzahl  in  16  number of words to copy; 0 is legal
- Aktiv  out  1  transfer in progress
- Fertig  out  1  one-cycle pulse at end of transfer (success or error)
- Fehler  out  1  sticky timeout flag; cleared by the next accepted Start
- Fortschritt  out  16  words written to RAM in the current/last transfer
- SdAdresse  out  32  word address presented to the SD reader
- SdLesen  out  1  one-cycle read request to the SD reader
- SdDaten  in  32  word returned by the SD reader
- SdFertig  in  1  SD reader data-valid (may stay high multiple cycles)
- SdBusy  in  1  SD reader busy; requests only allowed while low
- RamAdresse  out  32  RAM write address
- RamDaten  out  32  RAM write data
- RamSchreiben  out  1  RAM write request, held until accepted
- RamBereit  in  1  RAM accepts write in the cycle it is sampled high with RamSchreiben

## Operation
- States: IDLE, ANFRAGE, WARTEN, SCHREIBEN, WEITER.
- IDLE: Start=1 → latch QuellAdresse, ZielAdresse, Anzahl; clear Fehler and Fortschritt; Aktiv=1. If Anzahl=0 → Fertig pulse next cycle, Aktiv back to 0, no SD/RAM access. Else → ANFRAGE.
- ANFRAGE: wait for SdBusy=0; then drive SdLesen=1 for exactly one cycle with SdAdresse = current source address, reset timeout counter → WARTEN.
- WARTEN: registered copy of SdFertig gives edge detect; on rising edge (SdFertig=1, previous=0) capture SdDaten into RamDaten → SCHREIBEN. Timeout counter increments each cycle; reaching TIMEOUT → Fehler=1, Fertig pulse, Aktiv=0 → IDLE.
- SCHREIBEN: RamSchreiben=1, RamAdresse/RamDaten stable; when RamBereit=1 sampled → RamSchreiben=0, Fortschritt+1 → WEITER.
- WEITER: source and destination addresses +1 (mod 2^32); remaining count −1; remaining=0 → Fertig pulse, Aktiv=0 → IDLE; else → ANFRAGE.
- Start while Aktiv=1 is ignored. Input address/count changes after acceptance have no effect.

## Timing
- Reset (Reset=0) asynchronously forces: state IDLE, Aktiv=0, Fertig=0, Fehler=0, Fortschritt=0, SdLesen=0, SdAdresse=0, RamSchreiben=0, RamAdresse=0, RamDaten=0, timeout counter=0. Reset beats a simultaneous Start.
- Reset mid-transfer: abort immediately, no Fertig pulse; SD reader is not reset by this block; next transfer's ANFRAGE waits for SdBusy=0.
- Start at edge n (SdBusy=0, Anzahl≥1): Aktiv=1 after n; SdLesen=1 in cycle after n+1, low after n+2.
- SdFertig rising seen at edge m → RamSchreiben=1 after m; earliest write acceptance at m+1.
- Edge detect guarantees one word per read even though SdFertig stays high until the SD sector finishes; ANFRAGE waiting on SdBusy=0 guarantees SdFertig has fallen before the next request.
- Fertig is exactly one cycle, coincident with Aktiv falling.
- Fortschritt wraps never (max 65535 = Anzahl max).

## Test plan
- Anzahl=0, Start → Fertig pulse one cycle later, Aktiv low again, no SdLesen, no RamSchreiben, Fortschritt=0.
- Quelle=0x100, Ziel=0x2000, Anzahl=3, SD model returns 0xA0000000+addr with 20-cycle latency, RamBereit=1 → writes 0x2000/0xA0000100, 0x2001/0xA0000101, 0x2002/0xA0000102; one SdLesen per word; Fortschritt=3; single Fertig.
- Same run with RamBereit low for 5 cycles per write and SdFertig held high 30 cycles per word → data/addresses unchanged, RamSchreiben held steady, no duplicate writes, each SdLesen only after SdBusy=0.
- TIMEOUT=100, SD model never asserts SdFertig → Fehler=1 and Fertig pulse 100 cycles after SdLesen, Aktiv=0; next Start clears Fehler.
- Quelle=0xFFFFFFFF, Anzahl=2 → SdAdresse 0xFFFFFFFF then 0x00000000; Start pulses during transfer ignored.
- Reset low during SCHREIBEN → all outputs zero immediately, no Fertig; new transfer after release completes correctly.

Source files
------------

// File: rtl/sd_lade_sequenzer.sv
// Copies a run of consecutive 32-bit words from the SD word reader into RAM,
// one read request and one write handshake per word, started by a single pulse.
module sd_lade_sequenzer #(
  parameter logic [23:0] TIMEOUT = 24'd1048575
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic [31:0] i_QuellAdresse,
  input  logic [31:0] i_ZielAdresse,
  input  logic [15:0] i_Anzahl,
  output logic        o_Aktiv,
  output logic        o_Fertig,
  output logic        o_Fehler,
  output logic [15:0] o_Fortschritt,
  output logic [31:0] o_SdAdresse,
  output logic        o_SdLesen,
  input  logic [31:0] i_SdDaten,
  input  logic        i_SdFertig,
  input  logic        i_SdBusy,
  output logic [31:0] o_RamAdresse,
  output logic [31:0] o_RamDaten,
  output logic        o_RamSchreiben,
  input  logic        i_RamBereit
);

  typedef enum logic [2:0] {
    IDLE,
    ANFRAGE,
    WARTEN,
    SCHREIBEN,
    WEITER
  } t_zustand;

  t_zustand    r_zustand;
  t_zustand    w_zustand_next;

  logic [31:0] r_quelle;
  logic [31:0] r_ziel;
  logic [15:0] r_rest;
  logic [23:0] r_timeout;
  logic        r_sd_fertig_d;
  logic        r_aktiv;
  logic        r_fertig;
  logic        r_fehler;
  logic [15:0] r_fortschritt;
  logic [31:0] r_sd_adresse;
  logic        r_sd_lesen;
  logic [31:0] r_ram_adresse;
  logic [31:0] r_ram_daten;
  logic        r_ram_schreiben;

  logic        w_annahme;
  logic        w_anfrage;
  logic        w_erfassen;
  logic        w_zeitueberschreitung;
  logic        w_geschrieben;
  logic        w_weiter;
  logic        w_ende;
  logic        w_sd_flanke;
  logic        w_timeout_erreicht;
  logic [24:0] w_timeout_plus1;

  // SdFertig stays high for a whole sector; only its rising edge marks a new word.
  assign w_sd_flanke        = i_SdFertig & ~r_sd_fertig_d;
  assign w_timeout_plus1    = {1'b0, r_timeout} + 25'd1;
  assign w_timeout_erreicht = (w_timeout_plus1 >= {1'b0, TIMEOUT});

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_zustand <= IDLE;
    end else begin
      r_zustand <= w_zustand_next;
    end
  end

  always_comb begin
    w_zustand_next        = r_zustand;
    w_annahme             = 1'b0;
    w_anfrage             = 1'b0;
    w_erfassen            = 1'b0;
    w_zeitueberschreitung = 1'b0;
    w_geschrieben         = 1'b0;
    w_weiter              = 1'b0;
    w_ende                = 1'b0;
    case (r_zustand)
      IDLE: begin
        if (i_Start) begin
          w_annahme = 1'b1;
          // An empty transfer still passes through WEITER so Fertig comes one cycle later.
          w_zustand_next = (i_Anzahl == 16'd0) ? WEITER : ANFRAGE;
        end
      end
      ANFRAGE: begin
        if (!i_SdBusy) begin
          w_anfrage      = 1'b1;
          w_zustand_next = WARTEN;
        end
      end
      WARTEN: begin
        if (w_sd_flanke) begin
          w_erfassen     = 1'b1;
          w_zustand_next = SCHREIBEN;
        end else if (w_timeout_erreicht) begin
          w_zeitueberschreitung = 1'b1;
          w_zustand_next        = IDLE;
        end
      end
      SCHREIBEN: begin
        if (i_RamBereit) begin
          w_geschrieben  = 1'b1;
          w_zustand_next = WEITER;
        end
      end
      WEITER: begin
        w_weiter = 1'b1;
        if (r_rest <= 16'd1) begin
          w_ende         = 1'b1;
          w_zustand_next = IDLE;
        end else begin
          w_zustand_next = ANFRAGE;
        end
      end
      default: w_zustand_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_quelle        <= '0;
      r_ziel          <= '0;
      r_rest          <= '0;
      r_timeout       <= '0;
      r_sd_fertig_d   <= 1'b0;
      r_aktiv         <= 1'b0;
      r_fertig        <= 1'b0;
      r_fehler        <= 1'b0;
      r_fortschritt   <= '0;
      r_sd_adresse    <= '0;
      r_sd_lesen      <= 1'b0;
      r_ram_adresse   <= '0;
      r_ram_daten     <= '0;
      r_ram_schreiben <= 1'b0;
    end else begin
      r_sd_fertig_d <= i_SdFertig;
      r_fertig      <= w_ende | w_zeitueberschreitung;
      r_sd_lesen    <= w_anfrage;

      if (w_annahme) begin
        r_quelle      <= i_QuellAdresse;
        r_ziel        <= i_ZielAdresse;
        r_rest        <= i_Anzahl;
        r_fehler      <= 1'b0;
        r_fortschritt <= '0;
        r_aktiv       <= 1'b1;
      end

      if (w_anfrage) begin
        r_sd_adresse <= r_quelle;
        r_timeout    <= '0;
      end else if (r_zustand == WARTEN) begin
        r_timeout <= r_timeout + 24'd1;
      end

      if (w_erfassen) begin
        r_ram_daten     <= i_SdDaten;
        r_ram_adresse   <= r_ziel;
        r_ram_schreiben <= 1'b1;
      end

      if (w_geschrieben) begin
        r_ram_schreiben <= 1'b0;
        r_fortschritt   <= r_fortschritt + 16'd1;
      end

      if (w_weiter) begin
        r_quelle <= r_quelle + 32'd1;
        r_ziel   <= r_ziel + 32'd1;
        if (r_rest != 16'd0) begin
          r_rest <= r_rest - 16'd1;
        end
      end

      if (w_ende | w_zeitueberschreitung) begin
        r_aktiv <= 1'b0;
      end
      if (w_zeitueberschreitung) begin
        r_fehler <= 1'b1;
      end
    end
  end

  assign o_Aktiv        = r_aktiv;
  assign o_Fertig       = r_fertig;
  assign o_Fehler       = r_fehler;
  assign o_Fortschritt  = r_fortschritt;
  assign o_SdAdresse    = r_sd_adresse;
  assign o_SdLesen      = r_sd_lesen;
  assign o_RamAdresse   = r_ram_adresse;
  assign o_RamDaten     = r_ram_daten;
  assign o_RamSchreiben = r_ram_schreiben;

endmodule
